// File: rtl/mod3_seq_monitor.sv
// mod3_seq_monitor: watches the upstream mod-3 counter, emits a one-hot phase,
// counts wraps and runs a sequence lock / fault tracker.
module mod3_seq_monitor #(
  parameter int LOCK_CNT = 6,
  parameter int WRAP_W   = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [1:0]        count,
  input  logic              clr_err,
  output logic [2:0]        phase,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              locked,
  output logic              fault,
  output logic [1:0]        err_code
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

  localparam logic [1:0] E_HOLD = 2'b01;
  localparam logic [1:0] E_SEQ  = 2'b10;
  localparam logic [1:0] E_ILL  = 2'b11;

  typedef enum logic [1:0] {
    WAIT,
    ACQUIRE,
    LOCKED,
    FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       prev;
  logic             primed;
  logic [RUN_W-1:0] run, run_nxt, run_inc;
  logic [1:0]       err_nxt, cls;
  logic [2:0]       phase_nxt;
  logic             legal, is_err, wrap_nxt;

  // prev==11 is a recovery point: only 00 may follow
  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (prev == 2'b00): legal = (count == 2'b01);
      (prev == 2'b01): legal = (count == 2'b10);
      (prev == 2'b10): legal = (count == 2'b00);
      default:         legal = (count == 2'b00);
    endcase
  end

  always_comb begin
    cls = E_SEQ;
    unique case (1'b1)
      (count == 2'b11):                    cls = E_ILL;
      (count != 2'b11 && count == prev):   cls = E_HOLD;
      default:                             cls = E_SEQ;
    endcase
  end

  always_comb begin
    phase_nxt = 3'b000;
    unique case (1'b1)
      (count == 2'b00): phase_nxt = 3'b001;
      (count == 2'b01): phase_nxt = 3'b010;
      (count == 2'b10): phase_nxt = 3'b100;
      default:          phase_nxt = 3'b000;
    endcase
  end

  assign is_err   = primed & ~legal;
  assign wrap_nxt = primed & (prev == 2'b10) & (count == 2'b00);
  assign run_inc  = (run == RUN_MAX) ? run : run + RUN_W'(1);

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    err_nxt   = err_code;
    unique case (state)
      WAIT: begin
        state_nxt = ACQUIRE;
        run_nxt   = '0;
      end
      ACQUIRE: begin
        if (is_err) begin
          run_nxt = '0;
        end else begin
          run_nxt = run_inc;
          if (run_inc == RUN_MAX) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (is_err) begin
          state_nxt = FAULT;
          err_nxt   = cls;
        end
      end
      FAULT: begin
        if (clr_err) begin
          state_nxt = ACQUIRE;
          run_nxt   = '0;
          err_nxt   = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= WAIT;
      prev     <= 2'b00;
      primed   <= 1'b0;
      run      <= '0;
      phase    <= 3'b000;
      wrap     <= 1'b0;
      wraps    <= '0;
      err_code <= 2'b00;
    end else begin
      state    <= state_nxt;
      prev     <= count;
      primed   <= 1'b1;
      run      <= run_nxt;
      phase    <= phase_nxt;
      wrap     <= wrap_nxt;
      wraps    <= wraps + WRAP_W'(wrap_nxt);
      err_code <= err_nxt;
    end
  end

  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);

endmodule

// File: tb/tb_mod3_seq_monitor.sv
// tb_mod3_seq_monitor: drives a mod-3 counter (with forced faults) into the
// monitor and checks it against a sample-history model every cycle.
module tb_mod3_seq_monitor;

  localparam int LOCK = 6;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [1:0] count = 2'b00;
  logic       clr_err = 1'b0;
  logic [2:0] phase;
  logic       wrap;
  logic [7:0] wraps;
  logic       locked;
  logic       fault;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] cnt = 2'b00;

  mod3_seq_monitor #(.LOCK_CNT(LOCK), .WRAP_W(8)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .count(count),
    .clr_err(clr_err),
    .phase(phase),
    .wrap(wrap),
    .wraps(wraps),
    .locked(locked),
    .fault(fault),
    .err_code(err_code)
  );

  initial begin
    #2;
    forever #5 Clk = ~Clk;
  end

  // model: mode 0 wait, 1 acquire, 2 locked, 3 fault
  logic [1:0] m_prev = 2'b00;
  bit         m_primed = 1'b0;
  int         m_run = 0;
  int         m_mode = 0;
  int         m_err = 0;
  logic [2:0] m_phase = 3'b000;
  bit         m_wrap = 1'b0;
  int         m_wraps = 0;
  int         mc, pv, mcls;
  bit         mok;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_prev = 2'b00; m_primed = 0; m_run = 0; m_mode = 0;
      m_err = 0; m_phase = 3'b000; m_wrap = 0; m_wraps = 0;
    end else begin
      mc   = int'(count);
      pv   = int'(m_prev);
      mok  = (mc == ((pv == 3) ? 0 : (pv + 1) % 3));
      mcls = (mc == 3) ? 3 : (mc == pv) ? 1 : 2;
      m_wrap  = m_primed && pv == 2 && mc == 0;
      m_wraps = (m_wraps + int'(m_wrap)) % 256;
      if (!m_primed) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        if (mok) begin
          m_run++;
          if (m_run >= LOCK) m_mode = 2;
        end else m_run = 0;
      end else if (m_mode == 2) begin
        if (!mok) begin m_mode = 3; m_err = mcls; end
      end else if (m_mode == 3 && clr_err) begin
        m_mode = 1; m_run = 0; m_err = 0;
      end
      m_phase  = (mc == 3) ? 3'b000 : 3'(1 << mc);
      m_prev   = count;
      m_primed = 1;
    end
  end

  logic [15:0] exp_v, act_v;
  always @(negedge Clk) begin
    exp_v = {m_phase, m_wrap, 8'(m_wraps), m_mode == 2, m_mode == 3, 2'(m_err)};
    act_v = {phase, wrap, wraps, locked, fault, err_code};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] nx(input logic [1:0] c);
    return (c >= 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  task automatic step(input logic [1:0] v, input logic c);
    @(negedge Clk);
    cnt = v;
    count = v;
    clr_err = c;
  endtask

  task automatic look();
    @(posedge Clk);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(nx(cnt), 1'b0);
  endtask

  int pulses;
  int pw;

  initial begin
    #1 Rst = 1'b0;
    #3;
    chk("rst_phase", phase, 0);
    chk("rst_wraps", wraps, 0);
    chk("rst_flags", {locked, fault, wrap}, 0);
    chk("rst_err", err_code, 0);
    #7 Rst = 1'b1;

    // 1: clean run
    step(2'd0, 1'b0);
    adv(5);
    look();
    chk("t1_not_yet", locked, 0);
    chk("t1_wraps1", wraps, 1);
    chk("t1_phase", phase, 3'b100);
    adv(1);
    look();
    chk("t1_locked", locked, 1);
    chk("t1_wrap", wrap, 1);
    chk("t1_wraps2", wraps, 2);

    // 5: async reset while locked at wraps=5
    adv(9);
    look();
    chk("t5_wraps5", wraps, 5);
    chk("t5_locked", locked, 1);
    #1 Rst = 1'b0;
    cnt = 2'd0;
    count = 2'd0;
    #1;
    chk("t5_async", {phase, wrap, wraps, locked, fault, err_code}, 0);
    #8 Rst = 1'b1;
    step(2'd0, 1'b0);
    look();
    chk("t5_noerr", {fault, err_code}, 0);
    chk("t5_phase", phase, 3'b001);
    adv(6);
    look();
    chk("t5_relock", locked, 1);

    // 2: forced 11 while locked
    step(2'd3, 1'b0);
    look();
    chk("t2_fault", fault, 1);
    chk("t2_err", err_code, 3);
    chk("t2_locked", locked, 0);
    chk("t2_phase", phase, 0);
    adv(4);
    look();
    chk("t2_sticky", {fault, err_code}, 3'b111);

    // 4: clear together with a 00->10 SEQ error
    step(2'd0, 1'b0);
    step(2'd2, 1'b1);
    look();
    chk("t4_clear", {fault, err_code, locked}, 0);
    adv(5);
    look();
    chk("t4_not_yet", locked, 0);
    adv(1);
    look();
    chk("t4_relock", locked, 1);

    // 3: hold in ACQUIRE after 4 legal transitions
    step(cnt, 1'b0);
    look();
    chk("t3_holdfault", err_code, 1);
    step(nx(cnt), 1'b1);
    adv(4);
    step(cnt, 1'b0);
    look();
    chk("t3_noerr", {fault, err_code}, 0);
    chk("t3_cnt01", cnt, 1);
    adv(5);
    look();
    chk("t3_not_yet", locked, 0);
    adv(1);
    look();
    chk("t3_locked", locked, 1);

    // 6: 256 wraps with rollover
    pulses = 0;
    for (int i = 0; i < 768; i++) begin
      pw = m_wraps;
      step(nx(cnt), 1'b0);
      look();
      if (wrap) pulses++;
      if (pw == 254 && m_wraps == 255) chk("t6_ff", wraps, 255);
      if (pw == 255 && m_wraps == 0) chk("t6_roll", wraps, 0);
    end
    chk("t6_pulses", pulses, 256);
    chk("t6_locked", locked, 1);

    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
